fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage directly upstream of the 16-entry, 12-bit instruction memory.
- Drives `pc` into the memory and samples the combinational `instr` it returns into an instruction register (IR).
- Presents the IR to the decode stage over a valid/ready handshake.
- Handles start, halt-on-NOP, and PC redirect.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/sat_counter.sv | 36 +++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int PC_W_DEF    = 4;
  localparam int INSTR_W_DEF = 12;

  localparam logic [11:0] NOP_WORD = 12'h000;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// PC / instruction-fetch stage feeding decode over a valid/ready handshake.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count and stall_count.
//
// state | meaning
// IDLE  | after reset; pc parked at 0, waiting for start
// RUN   | fetching one word per free IR slot
// DRAIN | NOP fetched; waiting for decode to take it
// HALT  | stopped after NOP; waiting for start
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter bit HALT_ON_NOP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [7:0]         fetch_count,
  output logic [7:0]         stall_count
`endif
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;

  logic load_slot;
  logic is_nop;

  // IR may be (re)loaded when empty or being consumed this cycle
  assign load_slot = !valid_q || instr_ready;
  assign is_nop    = HALT_ON_NOP && (instr_in == INSTR_W'(NOP_WORD));

  // next-state and datapath updates; redirect outranks everything in RUN/DRAIN
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ir_d    = ir_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      IDLE: begin
        pc_d    = '0;
        valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
        end else if (load_slot) begin
          ir_d    = instr_in;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          if (is_nop) begin
            state_d = DRAIN;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          state_d = RUN;
        end else if (load_slot) begin
          valid_d = 1'b0;
          state_d = HALT;
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (start) begin
          pc_d    = '0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // state, pc and IR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
      ir_q    <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
    end
  end

  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = ir_q;
  assign instr_pc    = ipc_q;
  assign halted      = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic start_take;
  logic redirect_take;
  logic fetch_inc;
  logic stall_inc;

  assign start_take    = start && ((state_q == IDLE) || (state_q == HALT));
  assign redirect_take = redirect_valid && ((state_q == RUN) || (state_q == DRAIN));
  // a handshake that coincides with a redirect is a flush, not a delivery
  assign fetch_inc     = valid_q && instr_ready && !redirect_take;
  assign stall_inc     = valid_q && !instr_ready;

  sat_counter #(.W(8)) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_take),
    .inc   (fetch_inc),
    .count (fetch_count)
  );

  sat_counter #(.W(8)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_take),
    .inc   (stall_inc),
    .count (stall_count)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of single-cycle vectors plus
// hand-written sequences for redirect, async reset and pc wrap.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  pc;
  logic [11:0] instr_in;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr_out;
  logic [3:0]  instr_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [7:0]  fetch_count;
  logic [7:0]  stall_count;
`endif

  logic [11:0] mem [16];

  int checks;
  int failures;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pc             (pc),
    .instr_in       (instr_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  assign instr_in = mem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        ready;
    logic        rv;
    logic [3:0]  rpc;
    logic        e_valid;
    logic [11:0] e_out;
    logic [3:0]  e_ipc;
    logic [3:0]  e_pc;
    logic        e_halted;
    logic [7:0]  e_fcnt;
    logic [7:0]  e_scnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [11:0] o,
                          input logic [3:0] ip, input logic [3:0] p, input logic h);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(v));
    chk({tag, ".instr_out"},   32'(instr_out),   32'(o));
    chk({tag, ".instr_pc"},    32'(instr_pc),    32'(ip));
    chk({tag, ".pc"},          32'(pc),          32'(p));
    chk({tag, ".halted"},      32'(halted),      32'(h));
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] f, input logic [7:0] s);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(f));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(s));
`else
    if (f === 8'hxx || s === 8'hxx) $display("unexpected X in expected counters for %s", tag);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          start ready rv rpc  valid out      ipc pc halt fcnt scnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 4'd0, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 12'h120, 4'd0, 4'd1, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 12'h211, 4'd1, 4'd2, 1'b0, 8'd1, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 12'h320, 4'd2, 4'd3, 1'b0, 8'd2, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 12'h000, 4'd3, 4'd3, 1'b0, 8'd3, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 4'd3, 4'd3, 1'b1, 8'd4, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 12'h000, 4'd3, 4'd3, 1'b1, 8'd4, 8'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 4'd3, 4'd0, 1'b0, 8'd0, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 12'h120, 4'd0, 4'd1, 1'b0, 8'd0, 8'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 12'h211, 4'd1, 4'd2, 1'b0, 8'd1, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 12'h211, 4'd1, 4'd2, 1'b0, 8'd1, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 12'h211, 4'd1, 4'd2, 1'b0, 8'd1, 8'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 12'h211, 4'd1, 4'd2, 1'b0, 8'd1, 8'd3};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 12'h320, 4'd2, 4'd3, 1'b0, 8'd2, 8'd3};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 12'h000, 4'd3, 4'd3, 1'b0, 8'd3, 8'd3};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 4'd3, 4'd3, 1'b1, 8'd4, 8'd3};

    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    mem[0] = 12'h120;
    mem[1] = 12'h211;
    mem[2] = 12'h320;
    mem[3] = 12'h000;

    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 4'd0;
    instr_ready    = 1'b0;
    step();
    step();
    chk_outs("reset", 1'b0, 12'h000, 4'd0, 4'd0, 1'b0);
    chk_cnt("reset", 8'd0, 8'd0);
    rst_n = 1'b1;

    // redirect while IDLE must not move pc or start fetching
    redirect_valid = 1'b1;
    redirect_pc    = 4'd5;
    step();
    redirect_valid = 1'b0;
    step();
    chk_outs("idle_redirect", 1'b0, 12'h000, 4'd0, 4'd0, 1'b0);

    // run-to-halt, ignored redirect in HALT, restart, 3-cycle stall
    for (int i = 0; i < 16; i++) begin
      start          = vecs[i].start;
      instr_ready    = vecs[i].ready;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_out,
               vecs[i].e_ipc, vecs[i].e_pc, vecs[i].e_halted);
      chk_cnt($sformatf("vec%0d", i), vecs[i].e_fcnt, vecs[i].e_scnt);
    end
    start          = 1'b0;
    redirect_valid = 1'b0;

    // redirect to pc 2 while 0x211 is being handshaken: it is dropped
    instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_outs("rd_start", 1'b0, 12'h000, 4'd3, 4'd0, 1'b0);
    step();
    chk_outs("rd_f0", 1'b1, 12'h120, 4'd0, 4'd1, 1'b0);
    step();
    chk_outs("rd_f1", 1'b1, 12'h211, 4'd1, 4'd2, 1'b0);
    chk_cnt("rd_f1", 8'd1, 8'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 4'd2;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush.instr_valid", 32'(instr_valid), 32'd0);
    chk("rd_flush.pc", 32'(pc), 32'd2);
    chk_cnt("rd_flush", 8'd1, 8'd0);
    step();
    chk_outs("rd_after", 1'b1, 12'h320, 4'd2, 4'd3, 1'b0);
    chk_cnt("rd_after", 8'd1, 8'd0);

    // asynchronous reset in mid-cycle with a valid IR
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 12'h000, 4'd0, 4'd0, 1'b0);
    chk_cnt("async_rst", 8'd0, 8'd0);
    step();
    rst_n = 1'b1;

    // all-nonzero program: 17 accepts, pc wraps 15 -> 0
    for (int i = 0; i < 16; i++) mem[i] = 12'hA00 | 12'(i);
    instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_outs("wrap_start", 1'b0, 12'h000, 4'd0, 4'd0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      // start mid-RUN is a no-op
      start = (k == 5);
      step();
      chk_outs($sformatf("wrap%0d", k), 1'b1, 12'hA00 | 12'((k - 1) % 16),
               4'((k - 1) % 16), 4'(k % 16), 1'b0);
    end
    start = 1'b0;
    chk_cnt("wrap_end", 8'd16, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
